decode_stage: RTL and testbench

Registered instruction-decode stage for the RV32I core. It sits between the IF/ID boundary and ID/EX. It accepts fetched instructions over a valid/ready handshake and decodes them into the operand, immediate, register-enable and memory-op bundle. Decoded entries are buffered in a parametrised FIFO, and the head is held on a load-use hazard. It adds the things a plain combinational decoder lacks: back-pressure, flush, illegal-instruction detection, PC carry-through and optional M-extension decoding.

---
 rtl/decode_stage.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : Registered RV32I instruction-decode stage. Decodes the incoming
//            instruction word combinationally and writes the decoded bundle
//            into a small FIFO. The FIFO head is presented to ID/EX under a
//            valid/ready handshake and is held while a load-use hazard exists.
// Options  : DEC_RV32M_EN - when defined, OP with funct7=0000001 is a legal
//            M-extension op and out_muldiv is carried through the FIFO. When
//            undefined, that encoding is illegal and out_muldiv is tied to 0.
// Ports    : clk, rst_n (async, active-low), flush (sync discard)
//            in_valid/in_ready/in_instr/in_pc  - IF/ID side handshake
//            hz_valid/hz_rd                    - load in EX and its rd
//            out_valid/out_ready               - ID/EX side handshake
//            out_pc/op/funct3/funct7/imm/imm_en, rd/rs1/rs2 addr + enables,
//            out_mem_op, out_jump_en, out_illegal, out_muldiv - head bundle
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            hz_valid,
  input  logic [4:0]      hz_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_op,
  output logic [2:0]      out_funct3,
  output logic [7:0]      out_funct7,
  output logic [31:0]     out_imm,
  output logic            out_imm_en,
  output logic [4:0]      out_rd_addr,
  output logic [4:0]      out_rs1_addr,
  output logic [4:0]      out_rs2_addr,
  output logic            out_rd_en,
  output logic            out_rs1_en,
  output logic            out_rs2_en,
  output logic [4:0]      out_mem_op,
  output logic            out_jump_en,
  output logic            out_illegal,
  output logic            out_muldiv
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // pc + op + funct3 + funct7 + imm + imm_en + 3 addrs + 3 enables
  // + mem_op + jump_en + illegal
  localparam int BASE_W = PC_W + 75;
`ifdef DEC_RV32M_EN
  localparam int ENTRY_W = BASE_W + 1;
`else
  localparam int ENTRY_W = BASE_W;
`endif

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_opimm  = 7'b0010011;
  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_fence  = 7'b0001111;
  localparam logic [6:0] c_opc_system = 7'b1110011;

  localparam logic [4:0] c_mem_none   = 5'b00111;

  // --------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // --------------------------------------------------------------------------
  logic [6:0]  dec_opc;
  logic [4:0]  dec_rd;
  logic [2:0]  dec_funct3;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [6:0]  dec_funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  logic [31:0] dec_imm;
  logic        dec_has_imm;
  logic        dec_imm_en;
  logic        dec_illegal;
  logic        uses_rd;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        is_jump;
  logic        is_load;
  logic        is_store;
  logic        dec_rd_en;
  logic        dec_rs1_en;
  logic        dec_rs2_en;
  logic        dec_jump_en;
  logic [4:0]  dec_mem_op;
`ifdef DEC_RV32M_EN
  logic        dec_muldiv;
`endif

  assign dec_opc    = in_instr[6:0];
  assign dec_rd     = in_instr[11:7];
  assign dec_funct3 = in_instr[14:12];
  assign dec_rs1    = in_instr[19:15];
  assign dec_rs2    = in_instr[24:20];
  assign dec_funct7 = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'h000};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    dec_imm     = 32'h0;
    dec_has_imm = 1'b0;
    dec_illegal = 1'b0;
    uses_rd     = 1'b0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    is_jump     = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
`ifdef DEC_RV32M_EN
    dec_muldiv  = 1'b0;
`endif
    case (dec_opc)
      c_opc_lui, c_opc_auipc: begin
        dec_imm     = imm_u;
        dec_has_imm = 1'b1;
        uses_rd     = 1'b1;
      end
      c_opc_jal: begin
        dec_imm     = imm_j;
        dec_has_imm = 1'b1;
        uses_rd     = 1'b1;
        is_jump     = 1'b1;
      end
      c_opc_jalr: begin
        dec_imm     = imm_i;
        dec_has_imm = 1'b1;
        uses_rd     = 1'b1;
        uses_rs1    = 1'b1;
        is_jump     = 1'b1;
      end
      c_opc_branch: begin
        dec_imm     = imm_b;
        dec_has_imm = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        is_jump     = 1'b1;
        dec_illegal = (dec_funct3 == 3'b010) || (dec_funct3 == 3'b011);
      end
      c_opc_load: begin
        dec_imm     = imm_i;
        dec_has_imm = 1'b1;
        uses_rd     = 1'b1;
        uses_rs1    = 1'b1;
        is_load     = 1'b1;
        dec_illegal = (dec_funct3 == 3'b011) || (dec_funct3 == 3'b110) ||
                      (dec_funct3 == 3'b111);
      end
      c_opc_store: begin
        dec_imm     = imm_s;
        dec_has_imm = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        is_store    = 1'b1;
        dec_illegal = (dec_funct3 >= 3'b011);
      end
      c_opc_opimm: begin
        dec_imm     = imm_i;
        dec_has_imm = 1'b1;
        uses_rd     = 1'b1;
        uses_rs1    = 1'b1;
      end
      c_opc_op: begin
        uses_rd     = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        dec_illegal = (dec_funct7 != 7'b0000000) && (dec_funct7 != 7'b0100000);
`ifdef DEC_RV32M_EN
        if (dec_funct7 == 7'b0000001) begin
          dec_illegal = 1'b0;
          dec_muldiv  = 1'b1;
        end
`endif
      end
      c_opc_fence, c_opc_system: begin
        // No registers, immediate or memory access reported for these.
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Illegal instructions keep their raw fields but report no side effects.
  always_comb begin
    dec_rd_en   = uses_rd  && !dec_illegal && (dec_rd  != 5'd0);
    dec_rs1_en  = uses_rs1 && !dec_illegal && (dec_rs1 != 5'd0);
    dec_rs2_en  = uses_rs2 && !dec_illegal && (dec_rs2 != 5'd0);
    dec_jump_en = is_jump  && !dec_illegal;
    dec_imm_en  = dec_has_imm && !dec_illegal;
    dec_mem_op  = c_mem_none;
    if (!dec_illegal) begin
      if (is_load) begin
        dec_mem_op = {2'b01, dec_funct3};
      end else if (is_store) begin
        dec_mem_op = {2'b10, dec_funct3};
      end
    end
  end

  logic [ENTRY_W-1:0] dec_entry;
  assign dec_entry = {in_pc, dec_opc, dec_funct3, dec_funct7, dec_imm, dec_imm_en,
                      dec_rd, dec_rs1, dec_rs2, dec_rd_en, dec_rs1_en, dec_rs2_en,
                      dec_mem_op, dec_jump_en, dec_illegal
`ifdef DEC_RV32M_EN
                      , dec_muldiv
`endif
                      };

  // --------------------------------------------------------------------------
  // FIFO of decoded entries
  // --------------------------------------------------------------------------
  logic [ENTRY_W-1:0] entry_q [DEPTH];
  logic [ENTRY_W-1:0] entry_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_d;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;

  logic [ENTRY_W-1:0] head_entry;
  logic [6:0]         head_funct7;
  logic               stall;
  logic               push;
  logic               pop;

  assign head_entry = entry_q[rd_ptr_q];

  assign {out_pc, out_op, out_funct3, head_funct7, out_imm, out_imm_en,
          out_rd_addr, out_rs1_addr, out_rs2_addr, out_rd_en, out_rs1_en,
          out_rs2_en, out_mem_op, out_jump_en, out_illegal
`ifdef DEC_RV32M_EN
          , out_muldiv
`endif
          } = head_entry;

`ifndef DEC_RV32M_EN
  assign out_muldiv = 1'b0;
`endif

  assign out_funct7 = {1'b0, head_funct7};

  // Load-use hazard: the head reads the register a load in EX is producing.
  assign stall = hz_valid && (hz_rd != 5'd0) &&
                 ((out_rs1_en && (out_rs1_addr == hz_rd)) ||
                  (out_rs2_en && (out_rs2_addr == hz_rd)));

  assign out_valid = (count_q != '0) && !stall;
  // No full-bypass: a full FIFO refuses input even if the head pops now.
  assign in_ready  = (count_q < c_depth) && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (push && (wr_ptr_q == PTR_W'(i))) begin
        entry_d[i] = dec_entry;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // A pop in the flush cycle is consumed; everything else is dropped.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Scoreboard bench for decode_stage. Accepted instructions are
//            decoded by a reference model and queued; a monitor compares the
//            DUT head against the queue every cycle and pops on handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  localparam int PC_W  = 32;
  localparam int DEPTH = 2;
`ifdef DEC_RV32M_EN
  localparam bit M_ON = 1'b1;
`else
  localparam bit M_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            hz_valid;
  logic [4:0]      hz_rd;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      out_op;
  logic [2:0]      out_funct3;
  logic [7:0]      out_funct7;
  logic [31:0]     out_imm;
  logic            out_imm_en;
  logic [4:0]      out_rd_addr;
  logic [4:0]      out_rs1_addr;
  logic [4:0]      out_rs2_addr;
  logic            out_rd_en;
  logic            out_rs1_en;
  logic            out_rs2_en;
  logic [4:0]      out_mem_op;
  logic            out_jump_en;
  logic            out_illegal;
  logic            out_muldiv;

  always #5 clk = ~clk;

  decode_stage #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .hz_valid(hz_valid), .hz_rd(hz_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op(out_op), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_imm_en(out_imm_en),
    .out_rd_addr(out_rd_addr), .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
    .out_rd_en(out_rd_en), .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en),
    .out_mem_op(out_mem_op), .out_jump_en(out_jump_en),
    .out_illegal(out_illegal), .out_muldiv(out_muldiv)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [7:0]  f7;
    logic [31:0] imm;
    logic        imm_en;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_en;
    logic        rs1_en;
    logic        rs2_en;
    logic [4:0]  mem_op;
    logic        jump_en;
    logic        illegal;
    logic        muldiv;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = v;
    if (v[n-1]) begin
      for (int b = n; b < 32; b++) r[b] = 1'b1;
    end
    return r;
  endfunction

  // Reference decoder: classify the instruction, then apply the rules.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int   fmt;  // 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
    bit   wr_rd, rd1, rd2, jmp, ld, st, bad_i, md;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    fmt = 0; wr_rd = 0; rd1 = 0; rd2 = 0; jmp = 0; ld = 0; st = 0; bad_i = 0; md = 0;
    case (ins[6:0])
      7'h37, 7'h17: begin fmt = 4; wr_rd = 1; end
      7'h6f: begin fmt = 5; wr_rd = 1; jmp = 1; end
      7'h67: begin fmt = 1; wr_rd = 1; rd1 = 1; jmp = 1; end
      7'h63: begin fmt = 3; rd1 = 1; rd2 = 1; jmp = 1; bad_i = (f3 == 2 || f3 == 3); end
      7'h03: begin fmt = 1; wr_rd = 1; rd1 = 1; ld = 1; bad_i = (f3 == 3 || f3 >= 6); end
      7'h23: begin fmt = 2; rd1 = 1; rd2 = 1; st = 1; bad_i = (f3 >= 3); end
      7'h13: begin fmt = 1; wr_rd = 1; rd1 = 1; end
      7'h33: begin
        wr_rd = 1; rd1 = 1; rd2 = 1;
        md    = M_ON && (f7 == 7'd1);
        bad_i = !(f7 == 7'd0 || f7 == 7'd32 || md);
      end
      7'h0f, 7'h73: ;
      default: bad_i = 1;
    endcase
    e         = '0;
    e.pc      = pc;
    e.op      = ins[6:0];
    e.f3      = f3;
    e.f7      = {1'b0, f7};
    e.rd      = ins[11:7];
    e.rs1     = ins[19:15];
    e.rs2     = ins[24:20];
    case (fmt)
      1: e.imm = sx({20'h0, ins[31:20]}, 12);
      2: e.imm = sx({20'h0, ins[31:25], ins[11:7]}, 12);
      3: e.imm = sx({19'h0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
      4: e.imm = ins & 32'hFFFF_F000;
      5: e.imm = sx({11'h0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
      default: e.imm = 32'h0;
    endcase
    e.imm_en  = (fmt != 0) && !bad_i;
    e.rd_en   = wr_rd && !bad_i && (e.rd != 0);
    e.rs1_en  = rd1 && !bad_i && (e.rs1 != 0);
    e.rs2_en  = rd2 && !bad_i && (e.rs2 != 0);
    e.jump_en = jmp && !bad_i;
    e.illegal = bad_i;
    e.muldiv  = md && !bad_i;
    e.mem_op  = bad_i ? 5'h07 : ld ? {2'b01, f3} : st ? {2'b10, f3} : 5'h07;
    return e;
  endfunction

  // Acceptance/flush are sampled mid-cycle and applied to the scoreboard
  // at the edge where the DUT acts on them.
  bit          acc_pend = 0;
  bit          fl_pend  = 0;
  logic [31:0] cap_instr, cap_pc;

  always @(negedge clk) begin
    acc_pend  = rst_n && in_valid && in_ready;
    fl_pend   = rst_n && flush;
    cap_instr = in_instr;
    cap_pc    = in_pc;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (fl_pend) sb.delete();
      if (acc_pend) sb.push_back(model(cap_instr, cap_pc));
    end
    acc_pend = 0;
    fl_pend  = 0;
  end

  // Monitor
  always @(negedge clk) begin
    exp_t h;
    bit   stall_m;
    if (mon_en) begin
      chk("in_ready", {31'h0, in_ready}, {31'h0, (sb.size() < DEPTH) && !flush});
      if (sb.size() > 0) begin
        h = sb[0];
        stall_m = hz_valid && (hz_rd != 0) &&
                  ((h.rs1_en && h.rs1 == hz_rd) || (h.rs2_en && h.rs2 == hz_rd));
        chk("out_valid", {31'h0, out_valid}, {31'h0, !stall_m});
        chk("pc",      out_pc,                h.pc);
        chk("op",      {25'h0, out_op},       {25'h0, h.op});
        chk("funct3",  {29'h0, out_funct3},   {29'h0, h.f3});
        chk("funct7",  {24'h0, out_funct7},   {24'h0, h.f7});
        chk("imm",     out_imm,               h.imm);
        chk("imm_en",  {31'h0, out_imm_en},   {31'h0, h.imm_en});
        chk("rd",      {27'h0, out_rd_addr},  {27'h0, h.rd});
        chk("rs1",     {27'h0, out_rs1_addr}, {27'h0, h.rs1});
        chk("rs2",     {27'h0, out_rs2_addr}, {27'h0, h.rs2});
        chk("rd_en",   {31'h0, out_rd_en},    {31'h0, h.rd_en});
        chk("rs1_en",  {31'h0, out_rs1_en},   {31'h0, h.rs1_en});
        chk("rs2_en",  {31'h0, out_rs2_en},   {31'h0, h.rs2_en});
        chk("mem_op",  {27'h0, out_mem_op},   {27'h0, h.mem_op});
        chk("jump_en", {31'h0, out_jump_en},  {31'h0, h.jump_en});
        chk("illegal", {31'h0, out_illegal},  {31'h0, h.illegal});
        chk("muldiv",  {31'h0, out_muldiv},   {31'h0, h.muldiv});
        if (!stall_m && out_ready) void'(sb.pop_front());
      end else begin
        chk("out_valid_empty", {31'h0, out_valid}, 32'h0);
      end
    end
  end

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic hv, input logic [4:0] hrd,
                        input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    hz_valid  = hv;
    hz_rd     = hrd;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc;
    logic [6:0] f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    case ($urandom_range(0, 12))
      0: opc = 7'h37;  1: opc = 7'h17;  2: opc = 7'h6f;  3: opc = 7'h67;
      4: opc = 7'h63;  5: opc = 7'h03;  6: opc = 7'h23;  7: opc = 7'h13;
      8, 9: opc = 7'h33;  10: opc = 7'h0f;  11: opc = 7'h73;
      default: opc = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0: f7 = 7'd0;  1: f7 = 7'd32;  2: f7 = 7'd1;
      default: f7 = 7'($urandom);
    endcase
    f3  = 3'($urandom);
    rd  = 5'($urandom_range(0, 7));
    rs1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
    rs2 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  initial begin
    rst_n = 1'b0;
    set_in(0, 32'h0, 32'h0, 0, 0, 5'd0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready",  {31'h0, in_ready},  32'h1);
    chk("rst_imm",       out_imm,            32'h0);
    chk("rst_pc",        out_pc,             32'h0);
    chk("rst_mem_op",    {27'h0, out_mem_op}, 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // addi x1,x0,5 at 0x100
    set_in(1, 32'h0050_0093, 32'h100, 0, 0, 5'd0, 0);
    tick();
    set_in(0, 32'h0, 32'h0, 0, 0, 5'd0, 0);
    #1;
    chk("addi_valid",  {31'h0, out_valid},   32'h1);
    chk("addi_imm",    out_imm,              32'h5);
    chk("addi_rd_en",  {31'h0, out_rd_en},   32'h1);
    chk("addi_rd",     {27'h0, out_rd_addr}, 32'h1);
    chk("addi_rs1_en", {31'h0, out_rs1_en},  32'h0);
    chk("addi_mem_op", {27'h0, out_mem_op},  32'h07);
    chk("addi_pc",     out_pc,               32'h100);

    // pop addi, push sw x2,-4(x1)
    set_in(1, 32'hFE20_AE23, 32'h104, 1, 0, 5'd0, 0);
    tick();
    set_in(0, 32'h0, 32'h0, 0, 0, 5'd0, 0);
    #1;
    chk("sw_imm",    out_imm,              32'hFFFF_FFFC);
    chk("sw_mem_op", {27'h0, out_mem_op},  32'h12);
    chk("sw_rs1_en", {31'h0, out_rs1_en},  32'h1);
    chk("sw_rs2_en", {31'h0, out_rs2_en},  32'h1);
    chk("sw_rd_en",  {31'h0, out_rd_en},   32'h0);
    set_in(0, 32'h0, 32'h0, 1, 0, 5'd0, 0);
    tick();

    // Back-pressure: third push refused while full, even with a pop
    set_in(1, 32'h0010_0113, 32'h200, 0, 0, 5'd0, 0); tick();
    set_in(1, 32'h0020_0193, 32'h204, 0, 0, 5'd0, 0); tick();
    set_in(1, 32'h0030_0213, 32'h208, 0, 0, 5'd0, 0);
    #1;
    chk("full_in_ready", {31'h0, in_ready}, 32'h0);
    tick();
    out_ready = 1;
    #1;
    chk("full_pop_in_ready", {31'h0, in_ready}, 32'h0);
    tick();
    tick();
    set_in(0, 32'h0, 32'h0, 1, 0, 5'd0, 0);
    repeat (2) tick();

    // Load-use hazard on add x3,x2,x1
    set_in(1, 32'h0011_01B3, 32'h300, 1, 1, 5'd2, 0); tick();
    in_valid = 0;
    #1;
    chk("hz_valid0", {31'h0, out_valid}, 32'h0);
    tick();
    chk("hz_valid1", {31'h0, out_valid}, 32'h0);
    chk("hz_pc",     out_pc,             32'h300);
    hz_valid = 0;
    #1;
    chk("hz_release", {31'h0, out_valid}, 32'h1);
    chk("hz_pc2",     out_pc,             32'h300);
    tick();

    // mul x0,x1,x2
    set_in(1, 32'h0220_8033, 32'h400, 0, 0, 5'd0, 0); tick();
    in_valid = 0;
    #1;
    chk("mul_illegal", {31'h0, out_illegal}, {31'h0, !M_ON});
    chk("mul_muldiv",  {31'h0, out_muldiv},  {31'h0, M_ON});
    chk("mul_rs1_en",  {31'h0, out_rs1_en},  {31'h0, M_ON});
    chk("mul_rs2_en",  {31'h0, out_rs2_en},  {31'h0, M_ON});
    chk("mul_rd_en",   {31'h0, out_rd_en},   32'h0);
    out_ready = 1;
    tick();

    // Flush with two entries buffered and a new instruction offered
    set_in(1, 32'h0010_0113, 32'h500, 0, 0, 5'd0, 0); tick();
    set_in(1, 32'h0020_0193, 32'h504, 0, 0, 5'd0, 0); tick();
    set_in(1, 32'h0030_0213, 32'h508, 0, 0, 5'd0, 1);
    #1;
    chk("flush_in_ready", {31'h0, in_ready}, 32'h0);
    tick();
    set_in(0, 32'h0, 32'h0, 0, 0, 5'd0, 0);
    #1;
    chk("flush_out_valid", {31'h0, out_valid}, 32'h0);
    set_in(1, 32'h0040_0293, 32'h50C, 0, 0, 5'd0, 0); tick();
    in_valid = 0;
    #1;
    chk("post_flush_valid", {31'h0, out_valid}, 32'h1);
    chk("post_flush_pc",    out_pc,             32'h50C);

    // Asynchronous reset mid-stream
    set_in(1, 32'h0050_0313, 32'h600, 0, 0, 5'd0, 0); tick();
    in_valid = 0;
    #2;
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    sb.delete();
    chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("async_rst_pc",    out_pc,             32'h0);
    chk("async_rst_imm",   out_imm,            32'h0);
    chk("async_rst_ready", {31'h0, in_ready},  32'h1);
    @(posedge clk);
    #3;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 9) < 7, rand_instr(), {$urandom, 2'b00} >> 2 << 2,
             $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
             5'($urandom_range(0, 7)), $urandom_range(0, 99) < 3);
      tick();
    end

    set_in(0, 32'h0, 32'h0, 1, 0, 5'd0, 0);
    repeat (DEPTH + 3) tick();
    chk("drained", sb.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
